// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between fetch and load/store ports;
//            data port has priority, with a starvation guard and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ack,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  err,
  output logic                  stall_f,
  output logic                  stall_m,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [SC_W-1:0] c_starveMax = SC_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] c_toLast    = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_I_BUSY = 2'd1;
  localparam logic [1:0] c_D_BUSY = 2'd2;

  logic [1:0]        r_state;
  logic [SC_W-1:0]   r_starveCnt;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_iAck;
  logic              r_dAck;
  logic              r_err;
  logic [DATA_W-1:0] r_iRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_memReq;
  logic              r_memWe;
  logic [BE_W-1:0]   r_memBe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;

  logic w_iElig;
  logic w_dElig;
  logic w_idle;
  logic w_busy;
  logic w_grantI;
  logic w_grantD;
  logic w_timeout;
  logic w_done;

  // A port whose ack is out this cycle still shows its old req; ignore it.
  assign w_iElig   = i_req & ~r_iAck;
  assign w_dElig   = d_req & ~r_dAck;
  assign w_idle    = (r_state == c_IDLE);
  assign w_busy    = (r_state == c_I_BUSY) | (r_state == c_D_BUSY);
  assign w_grantI  = w_idle & w_iElig & (~w_dElig | (r_starveCnt == c_starveMax));
  assign w_grantD  = w_idle & w_dElig & ~w_grantI;
  assign w_timeout = w_busy & ~mem_ack & (r_toCnt == c_toLast);
  assign w_done    = w_busy & (mem_ack | w_timeout);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_toCnt    <= '0;
      r_iAck     <= 1'b0;
      r_dAck     <= 1'b0;
      r_err      <= 1'b0;
      r_iRdata   <= '0;
      r_dRdata   <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memBe    <= '0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_iAck <= 1'b0;
      r_dAck <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_grantI) begin
            r_state    <= c_I_BUSY;
            r_memReq   <= 1'b1;
            r_memWe    <= 1'b0;
            r_memBe    <= '1;
            r_memAddr  <= i_addr;
            r_memWdata <= '0;
            r_toCnt    <= '0;
          end else if (w_grantD) begin
            r_state    <= c_D_BUSY;
            r_memReq   <= 1'b1;
            r_memWe    <= d_we;
            r_memBe    <= d_be;
            r_memAddr  <= d_addr;
            r_memWdata <= d_wdata;
            r_toCnt    <= '0;
          end
        end
        c_I_BUSY, c_D_BUSY: begin
          if (w_done) begin
            r_state  <= c_IDLE;
            r_memReq <= 1'b0;
            r_err    <= w_timeout;
            if (r_state == c_I_BUSY) begin
              r_iAck   <= 1'b1;
              r_iRdata <= w_timeout ? '0 : mem_rdata;
            end else begin
              r_dAck   <= 1'b1;
              r_dRdata <= (w_timeout | r_memWe) ? '0 : mem_rdata;
            end
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
        end
        default: begin
          r_state  <= c_IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

  // Counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starveCnt <= '0;
    end else if (!i_req || w_grantI) begin
      r_starveCnt <= '0;
    end else if (w_grantD && (r_starveCnt != c_starveMax)) begin
      r_starveCnt <= r_starveCnt + SC_W'(1);
    end
  end

  assign i_ack     = r_iAck;
  assign d_ack     = r_dAck;
  assign err       = r_err;
  assign i_rdata   = r_iRdata;
  assign d_rdata   = r_dRdata;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_be    = r_memBe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign stall_f   = i_req & ~r_iAck;
  assign stall_m   = d_req & ~r_dAck;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized scoreboard bench for mem_port_arbiter with an
//            address-driven memory responder and reference expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SL = 4;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          stall_f;
  logic          stall_m;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t iQ[$];
  exp_t dQ[$];

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory contents are a fixed function of the address.
  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  // Address bits [13:12] select responder behaviour: fast, last-cycle ack, or hung.
  function automatic int delayOf(input logic [AW-1:0] a);
    case (a[13:12])
      2'd1:    return TO - 1;
      2'd2:    return -1;
      default: return int'(a[5:4]);
    endcase
  endfunction

  function automatic logic [AW-1:0] randAddr(input logic isData);
    logic [AW-1:0] a;
    int r;
    a = $urandom;
    a[31] = isData;
    a[1:0] = 2'b00;
    r = $urandom_range(0, 19);
    a[13:12] = (r < 16) ? 2'd0 : ((r < 18) ? 2'd1 : 2'd2);
    return a;
  endfunction

  function automatic exp_t mkExp(input logic [AW-1:0] a, input logic we);
    exp_t e;
    e.err   = (a[13:12] == 2'd2);
    e.rdata = (e.err || we) ? '0 : memData(a);
    return e;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not as required at %0t", name, $time);
  endtask

  initial begin : memResp
    int  k;
    int  dly;
    logic prev;
    k = 0;
    prev = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (!reset || !mem_req) begin
        prev = 1'b0;
        k = 0;
        mem_ack = reset && ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end else begin
        k = prev ? k + 1 : 0;
        prev = 1'b1;
        dly = delayOf(mem_addr);
        mem_ack = (k == dly);
        mem_rdata = mem_ack ? memData(mem_addr) : $urandom;
      end
    end
  end

  initial begin : monitor
    logic pIack, pDack, pMreq, iEl, dEl, expD, sWe;
    logic [DW-1:0] lastI, lastD, sWdata;
    logic [AW-1:0] sAddr;
    logic [BW-1:0] sBe;
    int starve;
    exp_t e;
    pIack = 1'b0; pDack = 1'b0; pMreq = 1'b0;
    lastI = '0; lastD = '0; starve = 0;
    sAddr = '0; sWe = 1'b0; sBe = '0; sWdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        pIack = 1'b0; pDack = 1'b0; pMreq = 1'b0;
        lastI = '0; lastD = '0; starve = 0;
      end else begin
        check("stall_f", 32'(stall_f), 32'(i_req & ~i_ack));
        check("stall_m", 32'(stall_m), 32'(d_req & ~d_ack));
        if (i_ack && d_ack) failNow("dual_ack");
        if (err && !(i_ack || d_ack)) failNow("err_without_ack");
        if (i_ack) begin
          if (iQ.size() == 0) failNow("i_ack_unexpected");
          else begin
            e = iQ.pop_front();
            check("i_rdata", i_rdata, e.rdata);
            check("i_err", 32'(err), 32'(e.err));
          end
          lastI = i_rdata;
        end else check("i_rdata_hold", i_rdata, lastI);
        if (d_ack) begin
          if (dQ.size() == 0) failNow("d_ack_unexpected");
          else begin
            e = dQ.pop_front();
            check("d_rdata", d_rdata, e.rdata);
            check("d_err", 32'(err), 32'(e.err));
          end
          lastD = d_rdata;
        end else check("d_rdata_hold", d_rdata, lastD);

        iEl = i_req & ~pIack;
        dEl = d_req & ~pDack;
        if (!pMreq) begin
          check("grant", 32'(mem_req), 32'(iEl | dEl));
          if (mem_req) begin
            expD = dEl && !(iEl && starve == SL);
            if (expD) begin
              check("d_mem_addr", mem_addr, d_addr);
              check("d_mem_we", 32'(mem_we), 32'(d_we));
              check("d_mem_be", 32'(mem_be), 32'(d_be));
              if (d_we) check("d_mem_wdata", mem_wdata, d_wdata);
            end else begin
              check("i_mem_addr", mem_addr, i_addr);
              check("i_mem_we", 32'(mem_we), 32'(1'b0));
              check("i_mem_be", 32'(mem_be), 32'({BW{1'b1}}));
            end
            sAddr = mem_addr; sWe = mem_we; sBe = mem_be; sWdata = mem_wdata;
            if (!expD) starve = 0;
            else if (i_req && starve < SL) starve++;
          end
        end else if (mem_req) begin
          check("mem_addr_stable", mem_addr, sAddr);
          check("mem_ctl_stable", 32'({mem_we, mem_be}), 32'({sWe, sBe}));
          check("mem_wdata_stable", mem_wdata, sWdata);
        end
        if (!i_req) starve = 0;
        pIack = i_ack; pDack = d_ack; pMreq = mem_req;
      end
    end
  end

  task automatic runFetch(input int n);
    logic got;
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      if ($urandom_range(0, 2) == 0) begin
        i_req = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clock);
      end
      i_addr = randAddr(1'b0);
      i_req = 1'b1;
      iQ.push_back(mkExp(i_addr, 1'b0));
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clock);
        #1;
        got = i_ack;
      end
      if (!got) failNow("i_ack_wait_expired");
    end
    @(negedge clock);
    i_req = 1'b0;
  endtask

  task automatic runData(input int n);
    logic got;
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clock);
      end
      d_addr  = randAddr(1'b1);
      d_we    = 1'($urandom_range(0, 1));
      d_be    = BW'($urandom);
      d_wdata = $urandom;
      d_req   = 1'b1;
      dQ.push_back(mkExp(d_addr, d_we));
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clock);
        #1;
        got = d_ack;
      end
      if (!got) failNow("d_ack_wait_expired");
    end
    @(negedge clock);
    d_req = 1'b0;
  endtask

  initial begin : main
    logic got;
    int   lat;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'(1'b0));
    check("rst_i_ack", 32'(i_ack), 32'(1'b0));
    check("rst_d_ack", 32'(d_ack), 32'(1'b0));
    check("rst_err", 32'(err), 32'(1'b0));
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_ctl", 32'({mem_we, mem_be}), '0);
    @(negedge clock);
    reset = 1'b1;

    fork
      runFetch(150);
      runData(150);
    join
    repeat (4) @(negedge clock);
    check("iQ_drained", 32'(iQ.size()), '0);
    check("dQ_drained", 32'(dQ.size()), '0);

    // Abandon a hung load with an asynchronous reset, then serve a held fetch.
    d_addr = 32'h8000_2000;
    d_we   = 1'b0;
    d_req  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clock);
      #1;
      got = mem_req;
    end
    if (!got) failNow("mid_op_grant_wait_expired");
    @(negedge clock);
    i_addr = 32'h0000_0100;
    i_req  = 1'b1;
    repeat (2) @(negedge clock);
    check("pre_rst_mem_req", 32'(mem_req), 32'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'(1'b0));
    check("async_rst_d_ack", 32'(d_ack), 32'(1'b0));
    check("async_rst_i_ack", 32'(i_ack), 32'(1'b0));
    check("async_rst_err", 32'(err), 32'(1'b0));
    @(negedge clock);
    d_req = 1'b0;
    iQ.push_back(mkExp(i_addr, 1'b0));
    @(negedge clock);
    reset = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clock);
      #1;
      lat++;
      got = i_ack;
    end
    if (!got) failNow("post_rst_i_ack_wait_expired");
    else check("post_rst_fetch_latency", 32'(lat), 32'(2));
    @(negedge clock);
    i_req = 1'b0;
    repeat (4) @(negedge clock);
    check("final_iQ_drained", 32'(iQ.size()), '0);
    check("final_dQ_drained", 32'(dQ.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
